// File: rtl/score_keeper_if.sv
// Signal bundle between the game FSM / button inputs and the score engine.
// The score engine connects through the slave modport.
interface score_keeper_if;
    logic        START;
    logic        GAME_END;
    logic        HIT_BTN;
    logic        MISS_BTN;
    logic        SHOW_HIGH;
    logic [31:0] BINARY_SCORE;
    logic [31:0] HIGH_SCORE;
    logic [3:0]  COMBO;
    logic        PLAYING;
    logic        NEW_RECORD;

    modport master (
        output START, GAME_END, HIT_BTN, MISS_BTN, SHOW_HIGH,
        input  BINARY_SCORE, HIGH_SCORE, COMBO, PLAYING, NEW_RECORD
    );

    modport slave (
        input  START, GAME_END, HIT_BTN, MISS_BTN, SHOW_HIGH,
        output BINARY_SCORE, HIGH_SCORE, COMBO, PLAYING, NEW_RECORD
    );
endinterface

// File: rtl/score_keeper.sv
// Score engine: debounced HIT/MISS buttons, combo-multiplied saturating score,
// session high score and a registered display value for the 8-digit display.
//
// state | meaning
// IDLE  | after reset, score held at 0, waiting for START
// PLAY  | game running, button events score or break the combo
// OVER  | game ended, score frozen, high score / record flag valid
module score_keeper #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned BASE_POINTS     = 10,
    parameter int unsigned MAX_MULT        = 4,
    parameter int unsigned COMBO_TIMEOUT   = 50000000,
    parameter int unsigned MAX_SCORE       = 99999999
) (
    input logic            CLK,
    input logic            RST,
    score_keeper_if.slave  sk
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_W = (COMBO_TIMEOUT > 2) ? $clog2(COMBO_TIMEOUT) : 1;
    localparam logic [DB_W-1:0]  DB_LOAD  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(COMBO_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]      btn_raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      acc_q, acc_d_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [1:0]      btn_evt;
    logic            hit_evt, miss_evt;

    logic            clr_game, end_game, play_evt;

    logic [31:0]      score_q, high_q, bin_q;
    logic [3:0]       combo_q;
    logic [TMR_W-1:0] tmr_q;
    logic             new_rec_q;

    logic [4:0]  combo_p1, mult;
    logic [39:0] pts, sum_w;
    logic [31:0] score_hit;
    logic [3:0]  combo_hit;

    assign btn_raw = {sk.MISS_BTN, sk.HIT_BTN};

    // Down-counter per button: reloads while the synced level matches the
    // accepted one, accepts the new level on terminal count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            acc_q       <= '0;
            acc_d_q     <= '0;
            db_cnt_q[0] <= DB_LOAD;
            db_cnt_q[1] <= DB_LOAD;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            acc_d_q <= acc_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == acc_q[i]) begin
                    db_cnt_q[i] <= DB_LOAD;
                end else if (db_cnt_q[i] == '0) begin
                    acc_q[i]    <= sync2_q[i];
                    db_cnt_q[i] <= DB_LOAD;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] - 1'b1;
                end
            end
        end
    end

    assign btn_evt  = acc_q & ~acc_d_q;
    assign hit_evt  = btn_evt[0];
    assign miss_evt = btn_evt[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        clr_game = 1'b0;
        end_game = 1'b0;
        play_evt = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sk.START) begin
                    state_d  = ST_PLAY;
                    clr_game = 1'b1;
                end
            end
            ST_PLAY: begin
                if (sk.GAME_END) begin
                    state_d  = ST_OVER;
                    end_game = 1'b1;
                end else if (sk.START) begin
                    clr_game = 1'b1;
                end else begin
                    play_evt = 1'b1;
                end
            end
            ST_OVER: begin
                if (sk.START) begin
                    state_d  = ST_PLAY;
                    clr_game = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Wide sum so a large BASE_POINTS * mult cannot wrap before the clamp.
    always_comb begin
        combo_p1  = {1'b0, combo_q} + 5'd1;
        mult      = (combo_p1 > 5'(MAX_MULT)) ? 5'(MAX_MULT) : combo_p1;
        pts       = 40'(BASE_POINTS) * 40'(mult);
        sum_w     = 40'(score_q) + pts;
        score_hit = (sum_w > 40'(MAX_SCORE)) ? 32'(MAX_SCORE) : sum_w[31:0];
        combo_hit = (combo_q == 4'hf) ? 4'hf : combo_q + 4'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            score_q   <= '0;
            high_q    <= '0;
            combo_q   <= '0;
            tmr_q     <= TMR_LOAD;
            new_rec_q <= 1'b0;
            bin_q     <= '0;
        end else begin
            bin_q <= sk.SHOW_HIGH ? high_q : score_q;
            if (clr_game) begin
                score_q   <= '0;
                combo_q   <= '0;
                tmr_q     <= TMR_LOAD;
                new_rec_q <= 1'b0;
            end else if (end_game) begin
                if (score_q > high_q) begin
                    high_q    <= score_q;
                    new_rec_q <= 1'b1;
                end else begin
                    new_rec_q <= 1'b0;
                end
            end else if (play_evt) begin
                if (miss_evt) begin
                    combo_q <= '0;
                    tmr_q   <= TMR_LOAD;
                end else if (hit_evt) begin
                    score_q <= score_hit;
                    combo_q <= combo_hit;
                    tmr_q   <= TMR_LOAD;
                end else if (tmr_q == '0) begin
                    combo_q <= '0;
                    tmr_q   <= TMR_LOAD;
                end else begin
                    tmr_q <= tmr_q - 1'b1;
                end
            end
        end
    end

    assign sk.BINARY_SCORE = bin_q;
    assign sk.HIGH_SCORE   = high_q;
    assign sk.COMBO        = combo_q;
    assign sk.PLAYING      = (state_q == ST_PLAY);
    assign sk.NEW_RECORD   = new_rec_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper; a second instance with MAX_SCORE=25 shares
// the stimulus to exercise score saturation.
module tb_score_keeper;
    localparam int DB = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic start = 1'b0, game_end = 1'b0, hit_btn = 1'b0, miss_btn = 1'b0, show_high = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    score_keeper_if sk_if ();
    score_keeper_if sat_if ();

    assign sk_if.START      = start;
    assign sk_if.GAME_END   = game_end;
    assign sk_if.HIT_BTN    = hit_btn;
    assign sk_if.MISS_BTN   = miss_btn;
    assign sk_if.SHOW_HIGH  = show_high;
    assign sat_if.START     = start;
    assign sat_if.GAME_END  = game_end;
    assign sat_if.HIT_BTN   = hit_btn;
    assign sat_if.MISS_BTN  = miss_btn;
    assign sat_if.SHOW_HIGH = show_high;

    score_keeper #(
        .DEBOUNCE_CYCLES(DB), .BASE_POINTS(10), .MAX_MULT(4),
        .COMBO_TIMEOUT(100), .MAX_SCORE(99999999)
    ) u_dut (.CLK(CLK), .RST(RST), .sk(sk_if));

    score_keeper #(
        .DEBOUNCE_CYCLES(DB), .BASE_POINTS(10), .MAX_MULT(4),
        .COMBO_TIMEOUT(100), .MAX_SCORE(25)
    ) u_sat (.CLK(CLK), .RST(RST), .sk(sat_if));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse(input bit s, input bit e);
        start = s; game_end = e;
        cyc(1);
        start = 1'b0; game_end = 1'b0;
    endtask

    // Press HIT, wait (bounded) for the displayed score to reach exp, release.
    task automatic hit_expect(input logic [31:0] exp, input string tag);
        int n = 0;
        hit_btn = 1'b1;
        while (sk_if.BINARY_SCORE !== exp && n < DB + 6) begin
            cyc(1);
            n++;
        end
        chk(tag, sk_if.BINARY_SCORE, exp);
        while (n < 10) begin
            cyc(1);
            n++;
        end
        hit_btn = 1'b0;
        cyc(10);
    endtask

    task automatic btn_pulse(input bit h, input bit m, input int hold);
        hit_btn = h; miss_btn = m;
        cyc(hold);
        hit_btn = 1'b0; miss_btn = 1'b0;
        cyc(20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and idle lockout
        RST = 1'b1;
        cyc(3);
        RST = 1'b0;
        cyc(2);
        hit_btn = 1'b1;
        cyc(50);
        chk("idle_score", sk_if.BINARY_SCORE, 32'd0);
        chk("idle_combo", 32'(sk_if.COMBO), 32'd0);
        chk("idle_playing", 32'(sk_if.PLAYING), 32'd0);
        chk("idle_high", sk_if.HIGH_SCORE, 32'd0);
        hit_btn = 1'b0;
        cyc(20);

        // Combo ramp, with saturation on the MAX_SCORE=25 instance
        pulse(1'b1, 1'b0);
        cyc(1);
        chk("play_flag", 32'(sk_if.PLAYING), 32'd1);
        hit_expect(32'd10, "ramp1");
        chk("sat1", sat_if.BINARY_SCORE, 32'd10);
        hit_expect(32'd30, "ramp2");
        chk("sat2", sat_if.BINARY_SCORE, 32'd25);
        hit_expect(32'd60, "ramp3");
        chk("sat3", sat_if.BINARY_SCORE, 32'd25);
        hit_expect(32'd100, "ramp4");
        hit_expect(32'd140, "ramp5");
        chk("ramp_combo", 32'(sk_if.COMBO), 32'd5);

        // Game over at 140: new record
        pulse(1'b0, 1'b1);
        cyc(2);
        chk("over_high", sk_if.HIGH_SCORE, 32'd140);
        chk("over_rec", 32'(sk_if.NEW_RECORD), 32'd1);
        chk("over_playing", 32'(sk_if.PLAYING), 32'd0);
        btn_pulse(1'b1, 1'b0, 10);
        chk("over_frozen", sk_if.BINARY_SCORE, 32'd140);

        // New game: glitch, hits, miss, simultaneous hit+miss
        pulse(1'b1, 1'b0);
        cyc(2);
        chk("restart_score", sk_if.BINARY_SCORE, 32'd0);
        chk("restart_rec", 32'(sk_if.NEW_RECORD), 32'd0);
        btn_pulse(1'b1, 1'b0, 2);
        chk("glitch_score", sk_if.BINARY_SCORE, 32'd0);
        chk("glitch_combo", 32'(sk_if.COMBO), 32'd0);
        hit_expect(32'd10, "g2_hit1");
        hit_expect(32'd30, "g2_hit2");
        hit_expect(32'd60, "g2_hit3");
        btn_pulse(1'b0, 1'b1, 10);
        chk("miss_combo", 32'(sk_if.COMBO), 32'd0);
        chk("miss_score", sk_if.BINARY_SCORE, 32'd60);
        hit_expect(32'd70, "after_miss");
        chk("after_miss_combo", 32'(sk_if.COMBO), 32'd1);

        show_high = 1'b1;
        cyc(1);
        chk("show_high_on", sk_if.BINARY_SCORE, 32'd140);
        show_high = 1'b0;
        cyc(1);
        chk("show_high_off", sk_if.BINARY_SCORE, 32'd70);

        btn_pulse(1'b1, 1'b1, 10);
        chk("both_score", sk_if.BINARY_SCORE, 32'd70);
        chk("both_combo", 32'(sk_if.COMBO), 32'd0);

        // Combo timeout versus a quick follow-up hit
        hit_expect(32'd80, "to_hit1");
        cyc(100);
        chk("to_combo_clr", 32'(sk_if.COMBO), 32'd0);
        hit_expect(32'd90, "to_hit2");
        chk("to_combo", 32'(sk_if.COMBO), 32'd1);
        hit_expect(32'd110, "quick_hit");
        chk("quick_combo", 32'(sk_if.COMBO), 32'd2);

        // GAME_END beats START; lower score is not a record
        pulse(1'b1, 1'b1);
        cyc(2);
        chk("end_win_playing", 32'(sk_if.PLAYING), 32'd0);
        chk("low_high", sk_if.HIGH_SCORE, 32'd140);
        chk("low_rec", 32'(sk_if.NEW_RECORD), 32'd0);
        chk("low_frozen", sk_if.BINARY_SCORE, 32'd110);

        // START during PLAY restarts, then reset mid-game
        pulse(1'b1, 1'b0);
        cyc(2);
        hit_expect(32'd10, "g3_hit");
        pulse(1'b1, 1'b0);
        cyc(2);
        chk("inplay_restart", sk_if.BINARY_SCORE, 32'd0);
        chk("inplay_combo", 32'(sk_if.COMBO), 32'd0);
        chk("inplay_playing", 32'(sk_if.PLAYING), 32'd1);
        hit_expect(32'd10, "g3_hit2");
        RST = 1'b1;
        #1;
        chk("rst_score", sk_if.BINARY_SCORE, 32'd0);
        chk("rst_high", sk_if.HIGH_SCORE, 32'd0);
        chk("rst_combo", 32'(sk_if.COMBO), 32'd0);
        chk("rst_playing", 32'(sk_if.PLAYING), 32'd0);
        chk("rst_rec", 32'(sk_if.NEW_RECORD), 32'd0);
        cyc(3);
        RST = 1'b0;
        cyc(3);
        chk("post_rst_idle", 32'(sk_if.PLAYING), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
